// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the global-memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting index at or after i_ptr, wrapping.
module rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    always_comb begin
        int unsigned j;
        o_valid = 1'b0;
        o_idx   = '0;
        j       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(i_ptr) + k) % NUM_REQ;
            if (!o_valid && i_req[j[IDX_W-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one global-memory port among NUM_REQ requesters.
// Optional build macro ARB_HOST_PRIORITY_EN: requester 0 pre-empts round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_rd_req,
    input  logic [NUM_REQ-1:0]               req_wr_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wr_data,
    output logic [NUM_REQ-1:0]               req_ack,
    output logic [DATA_WIDTH-1:0]            req_rd_data,
    output logic                             busy,
    output logic                             mem_rd_req,
    output logic                             mem_wr_req,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wr_data,
    input  logic [DATA_WIDTH-1:0]            mem_rd_data,
    input  logic                             mem_ack
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    state_t                r_state, w_state_next;
    logic [IDX_W-1:0]      r_ptr, r_grant;
    logic                  r_is_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;

    logic [NUM_REQ-1:0]    w_req;
    logic                  w_pick_valid;
    logic [IDX_W-1:0]      w_pick_idx, w_win, w_ptr_next;
    logic                  w_ptr_upd;

    assign w_req = req_rd_req | req_wr_req;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

`ifdef ARB_HOST_PRIORITY_EN
    // Host grants leave ptr alone so the cores' rotation is not disturbed.
    assign w_win     = w_req[0] ? '0 : w_pick_idx;
    assign w_ptr_upd = !w_req[0];
`else
    assign w_win     = w_pick_idx;
    assign w_ptr_upd = 1'b1;
`endif

    assign w_ptr_next  = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;
    assign mem_addr    = r_addr;
    assign mem_wr_data = r_wdata;

    always_comb begin
        w_state_next = r_state;
        mem_rd_req   = 1'b0;
        mem_wr_req   = 1'b0;
        req_ack      = '0;
        req_rd_data  = '0;
        busy         = (r_state != IDLE);
        unique case (r_state)
            IDLE:  if (w_pick_valid) w_state_next = ISSUE;
            ISSUE: begin
                mem_rd_req   = !r_is_wr;
                mem_wr_req   = r_is_wr;
                w_state_next = WAIT;
            end
            WAIT:  if (mem_ack) w_state_next = RESP;
            RESP: begin
                req_ack      = ONE_HOT0 << r_grant;
                req_rd_data  = r_is_wr ? '0 : r_rdata;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_is_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_pick_valid) begin
                r_grant <= w_win;
                // Write wins when both strobes are set.
                r_is_wr <= req_wr_req[w_win];
                r_addr  <= req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
                r_wdata <= req_wr_data[w_win*DATA_WIDTH +: DATA_WIDTH];
                if (w_ptr_upd) r_ptr <= w_ptr_next;
            end
            if (r_state == WAIT && mem_ack) r_rdata <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small latency-configurable memory model.
module tb_mem_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic               clk;
    logic               rst;
    logic [NR-1:0]      req_rd_req, req_wr_req, req_ack;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wr_data;
    logic [DW-1:0]      req_rd_data, mem_wr_data, mem_rd_data;
    logic [AW-1:0]      mem_addr;
    logic               busy, mem_rd_req, mem_wr_req, mem_ack;
    logic               model_ack, stray_ack;
    int                 lat_cfg;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_rd_req  (req_rd_req),
        .req_wr_req  (req_wr_req),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .req_ack     (req_ack),
        .req_rd_data (req_rd_data),
        .busy        (busy),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_ack     (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ack = model_ack | stray_ack;

    // Memory model: sees the strobe mid-cycle, acks lat_cfg cycles later.
    initial begin
        logic [31:0] mem [0:255];
        logic [31:0] rd_hold;
        int          cnt;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[64] = 32'hDEADBEEF;
        mem[4]  = 32'hA0A0_0000;
        mem[8]  = 32'hA1A1_1111;
        mem[12] = 32'hA2A2_2222;
        mem[20] = 32'hA3A3_3333;
        model_ack   = 1'b0;
        mem_rd_data = '0;
        rd_hold     = '0;
        cnt         = 0;
        forever begin
            @(negedge clk);
            model_ack = 1'b0;
            if (rst) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        model_ack   = 1'b1;
                        mem_rd_data = rd_hold;
                    end
                end
                if (mem_wr_req) mem[mem_addr[9:2]] = mem_wr_data;
                if (mem_rd_req || mem_wr_req) begin
                    cnt     = lat_cfg;
                    rd_hold = mem[mem_addr[9:2]];
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
        req_rd_req[i]           = rd;
        req_wr_req[i]           = wr;
        req_addr[i*AW +: AW]    = a;
        req_wr_data[i*DW +: DW] = d;
    endtask

    task automatic wait_ack(input string tag, output int cyc,
                            output logic [NR-1:0] ack, output logic [DW-1:0] data);
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        ack  = '0;
        data = '0;
        while (!seen && cyc < 60) begin
            tick();
            cyc++;
            if (req_ack != '0) begin
                seen = 1'b1;
                ack  = req_ack;
                data = req_rd_data;
            end
        end
        if (!seen) check_eq({tag, "_ack_seen"}, 64'(seen), 64'd1);
    endtask

    initial begin
        int              cyc;
        logic [NR-1:0]   ack;
        logic [DW-1:0]   data;
        logic [DW-1:0]   exp_data [NR];
        logic [AW-1:0]   addrs    [NR];
        exp_data = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
        addrs    = '{32'h10, 32'h20, 32'h30, 32'h50};

        rst         = 1'b1;
        stray_ack   = 1'b0;
        lat_cfg     = 1;
        req_rd_req  = '0;
        req_wr_req  = '0;
        req_addr    = '0;
        req_wr_data = '0;
        tick();
        tick();
        rst = 1'b0;

        check_eq("rst_busy",     64'(busy),        64'd0);
        check_eq("rst_ack",      64'(req_ack),     64'd0);
        check_eq("rst_rd_data",  64'(req_rd_data), 64'd0);
        check_eq("rst_mem_rd",   64'(mem_rd_req),  64'd0);
        check_eq("rst_mem_wr",   64'(mem_wr_req),  64'd0);
        check_eq("rst_mem_addr", 64'(mem_addr),    64'd0);
        check_eq("rst_mem_wdat", 64'(mem_wr_data), 64'd0);

        // Single read by requester 2, 1-cycle memory.
        set_req(2, 1'b1, 1'b0, 32'h100, 32'h0);
        tick();
        check_eq("rd_issue_strobe", 64'(mem_rd_req), 64'd1);
        check_eq("rd_issue_nowr",   64'(mem_wr_req), 64'd0);
        check_eq("rd_issue_addr",   64'(mem_addr),   64'h100);
        check_eq("rd_issue_busy",   64'(busy),       64'd1);
        req_addr[2*AW +: AW] = 32'h200;
        tick();
        check_eq("rd_wait_addr_held", 64'(mem_addr),   64'h100);
        check_eq("rd_wait_strobe",    64'(mem_rd_req), 64'd0);
        check_eq("rd_wait_noack",     64'(req_ack),    64'd0);
        tick();
        check_eq("rd_resp_ack",  64'(req_ack),     64'b0100);
        check_eq("rd_resp_data", 64'(req_rd_data), 64'hDEADBEEF);
        set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check_eq("rd_idle_busy", 64'(busy),    64'd0);
        check_eq("rd_idle_ack",  64'(req_ack), 64'd0);

        // Requester 0: write then read back.
        set_req(0, 1'b0, 1'b1, 32'h40, 32'h12345678);
        tick();
        check_eq("wr_issue_strobe", 64'(mem_wr_req),  64'd1);
        check_eq("wr_issue_nord",   64'(mem_rd_req),  64'd0);
        check_eq("wr_issue_addr",   64'(mem_addr),    64'h40);
        check_eq("wr_issue_data",   64'(mem_wr_data), 64'h12345678);
        wait_ack("wr", cyc, ack, data);
        check_eq("wr_ack",     64'(ack),  64'b0001);
        check_eq("wr_rd_zero", 64'(data), 64'd0);
        check_eq("wr_latency", 64'(cyc),  64'd2);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        set_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
        wait_ack("rdback", cyc, ack, data);
        check_eq("rdback_ack",     64'(ack),  64'b0001);
        check_eq("rdback_data",    64'(data), 64'h12345678);
        check_eq("rdback_latency", 64'(cyc),  64'd3);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // All four together from ptr=0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, addrs[i], 32'h0);
        for (int g = 0; g < NR; g++) begin
            wait_ack($sformatf("all4_%0d", g), cyc, ack, data);
            check_eq($sformatf("all4_ack_%0d", g),  64'(ack),  64'(4'b0001 << g));
            check_eq($sformatf("all4_data_%0d", g), 64'(data), 64'(exp_data[g]));
            set_req(g, 1'b0, 1'b0, 32'h0, 32'h0);
            tick();
        end

        // ptr should be back at 0: requester 0 beats 1.
        set_req(0, 1'b1, 1'b0, addrs[0], 32'h0);
        set_req(1, 1'b1, 1'b0, addrs[1], 32'h0);
        wait_ack("ptr0", cyc, ack, data);
        check_eq("ptr0_ack", 64'(ack), 64'b0001);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Grant to 2 leaves ptr=3; then 0 and 3 compete.
        set_req(2, 1'b1, 1'b0, addrs[2], 32'h0);
        wait_ack("g2", cyc, ack, data);
        check_eq("g2_ack", 64'(ack), 64'b0100);
        set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        set_req(0, 1'b1, 1'b0, addrs[0], 32'h0);
        set_req(3, 1'b1, 1'b0, addrs[3], 32'h0);
        wait_ack("wrap1", cyc, ack, data);
`ifdef ARB_HOST_PRIORITY_EN
        check_eq("wrap1_ack", 64'(ack), 64'b0001);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
`else
        check_eq("wrap1_ack",  64'(ack),  64'b1000);
        check_eq("wrap1_data", 64'(data), 64'(exp_data[3]));
        set_req(3, 1'b0, 1'b0, 32'h0, 32'h0);
`endif
        tick();
        wait_ack("wrap2", cyc, ack, data);
`ifdef ARB_HOST_PRIORITY_EN
        check_eq("wrap2_ack", 64'(ack), 64'b1000);
`else
        check_eq("wrap2_ack",  64'(ack),  64'b0001);
        check_eq("wrap2_data", 64'(data), 64'(exp_data[0]));
`endif
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(3, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Stray ack in IDLE, then a 5-cycle memory.
        lat_cfg   = 5;
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        tick();
        check_eq("stray_busy", 64'(busy),    64'd0);
        check_eq("stray_ack",  64'(req_ack), 64'd0);
        set_req(1, 1'b1, 1'b0, addrs[1], 32'h0);
        tick();
        check_eq("slow_issue", 64'(mem_rd_req), 64'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq($sformatf("slow_wait_busy_%0d", k),  64'(busy),    64'd1);
            check_eq($sformatf("slow_wait_noack_%0d", k), 64'(req_ack), 64'd0);
        end
        tick();
        check_eq("slow_ack",  64'(req_ack),     64'b0010);
        check_eq("slow_data", 64'(req_rd_data), 64'(exp_data[1]));
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Reset while in WAIT.
        set_req(2, 1'b1, 1'b0, addrs[2], 32'h0);
        tick();
        tick();
        tick();
        check_eq("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        check_eq("midrst_busy",     64'(busy),        64'd0);
        check_eq("midrst_ack",      64'(req_ack),     64'd0);
        check_eq("midrst_rd_data",  64'(req_rd_data), 64'd0);
        check_eq("midrst_mem_rd",   64'(mem_rd_req),  64'd0);
        check_eq("midrst_mem_addr", 64'(mem_addr),    64'd0);
        lat_cfg = 1;
        set_req(0, 1'b1, 1'b0, addrs[0], 32'h0);
        set_req(1, 1'b1, 1'b0, addrs[1], 32'h0);
        wait_ack("post_rst", cyc, ack, data);
        check_eq("post_rst_ack",  64'(ack),  64'b0001);
        check_eq("post_rst_data", 64'(data), 64'(exp_data[0]));
        tick();
        // Both still requesting; ptr is 1 after plain round-robin, 0 under host priority.
        wait_ack("host_vs_core", cyc, ack, data);
`ifdef ARB_HOST_PRIORITY_EN
        check_eq("host_vs_core_ack", 64'(ack), 64'b0001);
`else
        check_eq("host_vs_core_ack", 64'(ack), 64'b0010);
`endif
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
